pll_lock_reset_seq: RTL and testbench

//  Consumer end of the core PLL: samples the PLL 'locked' flag and sequences system resets from it.

---
 rtl/pll_lock_reset_seq.sv | 143 ++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_seq.sv
// Samples the PLL lock flag and releases sys_rst, then cpu_rst, after lock has been stable.
// Optional lock-wait watchdog that pulses pll_rst is enabled by defining PLL_WDOG_EN.
module pll_lock_reset_seq #(
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_GAP     = 16,
  parameter int CNT_W         = 8,
  parameter int WDOG_CYCLES   = 65536
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             cpu_rst,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int MAX_A = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int MAX_B = (MAX_A > WDOG_CYCLES) ? MAX_A : WDOG_CYCLES;
  localparam int CW    = $clog2(MAX_B + 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    REL_SYS,
`ifdef PLL_WDOG_EN
    PLL_RST,
`endif
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             sys_rst_q, sys_rst_d, cpu_rst_q, cpu_rst_d;
  logic             ready_q, ready_d, lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic             locked_s;

  assign locked_s = sync2_q;

  always_comb begin
    sync1_d     = pll_locked;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    lock_lost_d = 1'b0;
    loss_cnt_d  = loss_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
`ifdef PLL_WDOG_EN
          if (cnt_q == CW'(WDOG_CYCLES - 1)) begin
            state_d = PLL_RST;
            cnt_d   = '0;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      STABLE, REL_SYS, RUN: begin
        // Loss outranks any stage advance decided on the same edge.
        if (!locked_s) begin
          state_d     = WAIT_LOCK;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
          loss_cnt_d  = (&loss_cnt_q) ? loss_cnt_q : loss_cnt_q + 1'b1;
        end else if (state_q == STABLE && cnt_q == CW'(STABLE_CYCLES - 1)) begin
          state_d = REL_SYS;
          cnt_d   = '0;
        end else if (state_q == REL_SYS && cnt_q == CW'(STAGE_GAP - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (state_q == RUN) begin
          cnt_d = cnt_q;
        end
      end
`ifdef PLL_WDOG_EN
      PLL_RST: begin
        if (cnt_q == CW'(7)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    sys_rst_d = !(state_d == REL_SYS || state_d == RUN);
    cpu_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sys_rst_q   <= 1'b1;
      cpu_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sys_rst_q   <= sys_rst_d;
      cpu_rst_q   <= cpu_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

`ifdef PLL_WDOG_EN
  logic pll_rst_q;
  always_ff @(posedge clk) begin
    if (rst) pll_rst_q <= 1'b0;
    else     pll_rst_q <= (state_d == PLL_RST);
  end
  assign pll_rst = pll_rst_q;
`else
  assign pll_rst = 1'b0;
`endif

  assign sys_rst   = sys_rst_q;
  assign cpu_rst   = cpu_rst_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
  assign loss_cnt  = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench: default-parameter instance for sequencing timing, small instance for saturation/watchdog.
module tb_pll_lock_reset_seq;

  logic       clk = 1'b0;
  logic       rst, pll_locked;
  logic       pll_rst, sys_rst, cpu_rst, ready, lock_lost;
  logic [7:0] loss_cnt;

  logic       rst2, pll_locked2;
  logic       pll_rst2, sys_rst2, cpu_rst2, ready2, lock_lost2;
  logic [1:0] loss_cnt2;

  int n_cmp = 0;
  int n_err = 0;
  int e = 0;

  always #5 clk = ~clk;

  pll_lock_reset_seq u_dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .sys_rst(sys_rst), .cpu_rst(cpu_rst), .ready(ready),
    .lock_lost(lock_lost), .loss_cnt(loss_cnt)
  );

  pll_lock_reset_seq #(.STABLE_CYCLES(4), .STAGE_GAP(2), .CNT_W(2), .WDOG_CYCLES(64)) u_small (
    .clk(clk), .rst(rst2), .pll_locked(pll_locked2), .pll_rst(pll_rst2),
    .sys_rst(sys_rst2), .cpu_rst(cpu_rst2), .ready(ready2),
    .lock_lost(lock_lost2), .loss_cnt(loss_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int target);
    while (e < target) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic s, input logic c, input logic r,
                            input logic l, input logic [7:0] n);
    check({tag, ".sys_rst"}, {31'd0, sys_rst}, {31'd0, s});
    check({tag, ".cpu_rst"}, {31'd0, cpu_rst}, {31'd0, c});
    check({tag, ".ready"}, {31'd0, ready}, {31'd0, r});
    check({tag, ".lock_lost"}, {31'd0, lock_lost}, {31'd0, l});
    check({tag, ".loss_cnt"}, {24'd0, loss_cnt}, {24'd0, n});
  endtask

  initial begin : stim
    int base;
    int waited;
    logic wd_exp;
    logic [1:0] sat_exp;
    rst = 1'b1; pll_locked = 1'b0;
    rst2 = 1'b1; pll_locked2 = 1'b0;
`ifdef PLL_WDOG_EN
    wd_exp = 1'b1;
`else
    wd_exp = 1'b0;
`endif

    // Reset held for four edges
    for (int i = 0; i < 4; i++) begin
      step();
      check_main("reset", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      check("reset.pll_rst", {31'd0, pll_rst}, 32'd0);
    end
    rst = 1'b0;

    // Lock rises before edge 100
    run_to(99);
    pll_locked = 1'b1;
    run_to(1125);
    check_main("pre_sys", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step();
    check_main("sys_rel", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    run_to(1141);
    check_main("pre_cpu", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    step();
    check_main("run", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    // One-cycle glitch in RUN
    run_to(1150);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    step();
    check_main("glitch_e1152", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    step();
    check_main("loss1", 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
    step();
    check_main("loss1_end", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    run_to(2177);
    check("reseq.pre_sys", {31'd0, sys_rst}, 32'd1);
    step();
    check("reseq.sys_rel", {31'd0, sys_rst}, 32'd0);
    run_to(2193);
    check("reseq.pre_cpu", {31'd0, cpu_rst}, 32'd1);
    step();
    check_main("reseq.run", 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);

    // Second glitch, then drop lock on the STABLE->REL_SYS edge
    run_to(2200);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    run_to(2203);
    check_main("loss2", 1'b1, 1'b1, 1'b0, 1'b1, 8'd2);
    run_to(3225);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    run_to(3227);
    check_main("edge_pre", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    step();
    check_main("edge_loss", 1'b1, 1'b1, 1'b0, 1'b1, 8'd3);
    step();
    check_main("edge_after", 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);

    // Synchronous reset while in REL_SYS
    run_to(4255);
    check_main("in_rel_sys", 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
    rst = 1'b1;
    step();
    check_main("rst_rel_sys", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;

    // Small instance: watchdog (or its absence) with lock absent
    base = e;
    rst2 = 1'b0;
    run_to(base + 63);
    check("wd.pre", {31'd0, pll_rst2}, 32'd0);
    step();
    check("wd.first", {31'd0, pll_rst2}, {31'd0, wd_exp});
    run_to(base + 71);
    check("wd.last", {31'd0, pll_rst2}, {31'd0, wd_exp});
    step();
    check("wd.off", {31'd0, pll_rst2}, 32'd0);
    run_to(base + 135);
    check("wd.pre2", {31'd0, pll_rst2}, 32'd0);
    step();
    check("wd.second", {31'd0, pll_rst2}, {31'd0, wd_exp});
    check("wd.sys_rst", {31'd0, sys_rst2}, 32'd1);
    check("wd.lock_lost", {31'd0, lock_lost2}, 32'd0);

    // Small instance: five loss events saturate a 2-bit counter
    run_to(base + 144);
    pll_locked2 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      waited = 0;
      while (ready2 !== 1'b1 && waited < 50) begin
        step();
        waited++;
      end
      check("sat.ready_reached", {31'd0, ready2}, 32'd1);
      pll_locked2 = 1'b0;
      step();
      pll_locked2 = 1'b1;
      step();
      step();
      sat_exp = (k >= 3) ? 2'd3 : 2'(k);
      check("sat.lock_lost", {31'd0, lock_lost2}, 32'd1);
      check("sat.loss_cnt", {30'd0, loss_cnt2}, {30'd0, sat_exp});
      check("sat.cpu_rst", {31'd0, cpu_rst2}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
